led_pattern_gen: RTL and testbench

//  Parametrised multi-mode LED pattern generator; successor to single-mode blinker on PYNQ-Z2 user LEDs.

---
 rtl/led_pattern_pkg.sv | 26 ++
 rtl/led_tick_div.sv | 40 ++++
 rtl/led_pattern_gen.sv | 157 +++++++++++++++
 tb/tb_led_pattern_gen.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg
//   Shared definitions for the LED pattern generator: 2-bit mode encodings
//   and the mode decode used at every pattern step.
//   Build option: LED_PATTERN_GEN_BREATHE_EN enables the BREATHE (PWM) mode.
//   Without it, mode 2'b11 is folded onto BLINK.
package led_pattern_pkg;

  localparam int MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_BLINK   = 2'b00;
  localparam mode_t MODE_CHASE   = 2'b01;
  localparam mode_t MODE_BOUNCE  = 2'b10;
  localparam mode_t MODE_BREATHE = 2'b11;

  // Mode as seen by the pattern FSM; BREATHE collapses to BLINK when not built.
  function automatic mode_t decode_mode(input mode_t m);
`ifdef LED_PATTERN_GEN_BREATHE_EN
    return m;
`else
    return (m == MODE_BREATHE) ? MODE_BLINK : m;
`endif
  endfunction

endpackage

// File: rtl/led_tick_div.sv
// led_tick_div
//   Step divider for the LED pattern generator. Counts 0..DIVISOR-1 while
//   enabled and wraps; the wrap edge is the pattern step edge.
// Ports
//   clk_100MHz  in   system clock
//   reset       in   synchronous, active-high
//   enable      in   1 = count, 0 = hold count, tick low
//   tick        out  registered one-cycle strobe, high in the cycle after a step edge
//   step        out  combinational step-edge qualifier (enable && count at terminal),
//                    lets the parent register its new pattern on the same edge as tick
module led_tick_div #(
  parameter int DIVISOR = 50_000_000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic enable,
  output logic tick,
  output logic step
);

  localparam int CNT_W = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt;

  assign step = enable && (cnt == CNT_LAST);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= step;
      if (enable) begin
        cnt <= step ? '0 : cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//   Multi-mode LED pattern generator: BLINK, CHASE, BOUNCE and (optionally)
//   BREATHE. A divider paces pattern steps; the mode input is only looked at
//   on step edges.
//   Build option: LED_PATTERN_GEN_BREATHE_EN builds the PWM counter and duty
//   logic for BREATHE; otherwise mode 2'b11 behaves exactly like BLINK.
// Ports
//   clk_100MHz  in   system clock
//   reset       in   synchronous, active-high
//   enable      in   1 = run, 0 = freeze divider, PWM counter and pattern
//   mode        in   00 BLINK, 01 CHASE, 10 BOUNCE, 11 BREATHE
//   led         out  registered LED drive
//   tick        out  one-cycle strobe, high in the cycle the pattern steps
//
// Pattern FSM (mode_q)
//   state    | meaning
//   BLINK    | all LEDs toggle each step
//   CHASE    | single lit LED rotates left
//   BOUNCE   | single lit LED walks up then down, dir_up gives direction
//   BREATHE  | duty ramps 0..max..0 (dir_up), LEDs follow pwm_cnt < duty
//   init_pending forces the next step to load a pattern instead of advancing.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int DIVISOR  = 50_000_000,
  parameter int PWM_BITS = 8
) (
  input  logic                clk_100MHz,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] led,
  output logic                tick
);

  localparam logic [NUM_LEDS-1:0] LED_ONE = NUM_LEDS'(1);

  logic                step;
  mode_t               mode_eff;
  mode_t               mode_q;
  mode_t               mode_nxt;
  logic                init_pending;
  logic                init_nxt;
  logic                load;
  logic                dir_up;
  logic                dir_nxt;
  logic [NUM_LEDS-1:0] led_nxt;
  logic [NUM_LEDS-1:0] chase_next;
  logic [NUM_LEDS-1:0] bounce_shift;

  led_tick_div #(
    .DIVISOR(DIVISOR)
  ) u_tick_div (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .enable    (enable),
    .tick      (tick),
    .step      (step)
  );

  assign mode_eff = decode_mode(mode);
  assign load     = init_pending || (mode_eff != mode_q);

  // Rotate left; for a single LED the two terms overlap and the bit stays put.
  assign chase_next   = (led << 1) | (led >> (NUM_LEDS - 1));
  assign bounce_shift = dir_up ? (led << 1) : (led >> 1);

`ifdef LED_PATTERN_GEN_BREATHE_EN
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] duty_nxt;
  logic [PWM_BITS-1:0] duty_step;

  assign duty_step = dir_up ? duty + PWM_BITS'(1) : duty - PWM_BITS'(1);
`endif

  always_comb begin
    mode_nxt = mode_q;
    init_nxt = init_pending;
    led_nxt  = led;
    dir_nxt  = dir_up;
`ifdef LED_PATTERN_GEN_BREATHE_EN
    duty_nxt = duty;
`endif
    if (step) begin
      mode_nxt = mode_eff;
      init_nxt = 1'b0;
      if (load) begin
        dir_nxt = 1'b1;
        case (mode_eff)
          MODE_CHASE, MODE_BOUNCE: led_nxt = LED_ONE;
`ifdef LED_PATTERN_GEN_BREATHE_EN
          MODE_BREATHE: duty_nxt = '0;
`endif
          default: led_nxt = '1;
        endcase
      end else begin
        case (mode_q)
          MODE_CHASE: led_nxt = chase_next;
          MODE_BOUNCE: begin
            // Direction flips on arrival at an end, so each end is shown once.
            if (NUM_LEDS > 1) begin
              led_nxt = bounce_shift;
              if (bounce_shift[NUM_LEDS-1]) begin
                dir_nxt = 1'b0;
              end else if (bounce_shift[0]) begin
                dir_nxt = 1'b1;
              end
            end
          end
`ifdef LED_PATTERN_GEN_BREATHE_EN
          MODE_BREATHE: begin
            duty_nxt = duty_step;
            if (duty_step == '1) begin
              dir_nxt = 1'b0;
            end else if (duty_step == '0) begin
              dir_nxt = 1'b1;
            end
          end
`endif
          default: led_nxt = ~led;
        endcase
      end
    end
`ifdef LED_PATTERN_GEN_BREATHE_EN
    // In BREATHE the LEDs follow the PWM compare every enabled cycle,
    // using the duty that is valid from this edge on.
    if (mode_nxt == MODE_BREATHE) begin
      led_nxt = {NUM_LEDS{pwm_cnt < duty_nxt}};
    end
`endif
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      led          <= '0;
      mode_q       <= MODE_BLINK;
      init_pending <= 1'b1;
      dir_up       <= 1'b1;
`ifdef LED_PATTERN_GEN_BREATHE_EN
      pwm_cnt      <= '0;
      duty         <= '0;
`endif
    end else if (enable) begin
      led          <= led_nxt;
      mode_q       <= mode_nxt;
      init_pending <= init_nxt;
      dir_up       <= dir_nxt;
`ifdef LED_PATTERN_GEN_BREATHE_EN
      pwm_cnt      <= pwm_cnt + PWM_BITS'(1);
      duty         <= duty_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen
//   Self-checking bench for led_pattern_gen (NUM_LEDS=4, DIVISOR=5, PWM_BITS=2).
//   A closed-form reference model (step index -> pattern) runs alongside the DUT.
module tb_led_pattern_gen;

  localparam int N    = 4;
  localparam int DIV  = 5;
  localparam int PB   = 2;
  localparam int DMAX = (1 << PB) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [N-1:0] led;
  logic         tick;

  int n_checks = 0;
  int n_errors = 0;

  led_pattern_gen #(
    .NUM_LEDS(N),
    .DIVISOR (DIV),
    .PWM_BITS(PB)
  ) dut (
    .clk_100MHz(clk),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .led       (led),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_div = 0;
  int         m_k = 0;
  int         m_pwm = 0;
  logic       m_pending = 1'b1;
  logic [1:0] m_mode = 2'b00;
  logic [3:0] m_led = 4'h0;
  logic       m_tick = 1'b0;
  logic [3:0] tbl[$];

  function automatic logic [1:0] eff_mode(input logic [1:0] m);
`ifdef LED_PATTERN_GEN_BREATHE_EN
    return m;
`else
    return (m == 2'd3) ? 2'd0 : m;
`endif
  endfunction

  function automatic int duty_of(input int k);
    int p;
    p = k % (2 * DMAX);
    return (p <= DMAX) ? p : 2 * DMAX - p;
  endfunction

  function automatic logic [3:0] pat_of(input logic [1:0] md, input int k);
    int p;
    int idx;
    case (md)
      2'd0: return (k % 2 == 0) ? 4'hF : 4'h0;
      2'd1: return 4'(1 << (k % N));
      2'd2: begin
        p   = k % (2 * N - 2);
        idx = (p < N) ? p : 2 * N - 2 - p;
        return 4'(1 << idx);
      end
      default: return 4'h0;
    endcase
  endfunction

  // One clock: advance the model with the inputs present at the edge, then
  // leave the caller 1 ns after the edge to sample the DUT.
  task automatic cycle();
    int         pwm_before;
    logic [1:0] em;
    @(posedge clk);
    if (reset) begin
      m_div = 0; m_k = 0; m_pwm = 0; m_pending = 1'b1;
      m_mode = 2'd0; m_led = 4'h0; m_tick = 1'b0;
    end else if (enable) begin
      m_tick     = (m_div == DIV - 1);
      m_div      = m_tick ? 0 : m_div + 1;
      pwm_before = m_pwm;
      m_pwm      = (m_pwm + 1) % (1 << PB);
      if (m_tick) begin
        em = eff_mode(mode);
        if (m_pending || em != m_mode) begin
          m_mode = em; m_pending = 1'b0; m_k = 0;
        end else begin
          m_k++;
        end
        if (m_mode != 2'd3) m_led = pat_of(m_mode, m_k);
      end
      if (m_mode == 2'd3) m_led = (pwm_before < duty_of(m_k)) ? 4'hF : 4'h0;
    end else begin
      m_tick = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset(input logic [1:0] md);
    reset = 1'b1; enable = 1'b1; mode = md;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; mode = 2'b00;
    cycle();
    cycle();
    n_checks++;
    if (led !== 4'h0 || tick !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state led=%b tick=%b want led=0000 tick=0", led, tick);
    end
    reset = 1'b0;
  endtask

  // Runs one mode from reset, checks every cycle against the model, the
  // LED value at each tick against tbl, and the first-tick latency.
  task automatic test_pattern(input string name, input logic [1:0] md, input int ncyc);
    int nt = 0;
    int first = -1;
    do_reset(md);
    for (int c = 1; c <= ncyc; c++) begin
      cycle();
      n_checks++;
      if (led !== m_led || tick !== m_tick) begin
        n_errors++;
        $display("FAIL %s_cycle c=%0d led=%b tick=%b want led=%b tick=%b",
                 name, c, led, tick, m_led, m_tick);
      end
      if (tick && first < 0) first = c;
      if (m_tick) begin
        if (nt < tbl.size()) begin
          n_checks++;
          if (led !== tbl[nt]) begin
            n_errors++;
            $display("FAIL %s_tick%0d led=%b want %b", name, nt, led, tbl[nt]);
          end
        end
        nt++;
      end
    end
    n_checks++;
    if (first != DIV) begin
      n_errors++;
      $display("FAIL %s_first_tick got cycle %0d want %0d", name, first, DIV);
    end
  endtask

  task automatic test_breathe();
`ifdef LED_PATTERN_GEN_BREATHE_EN
    int exp_on[7] = '{0, 1, 2, 3, 2, 1, 0};
    int nt = 0;
    int win = 4;
    int ones = 0;
    do_reset(2'b11);
    for (int c = 1; c <= 40; c++) begin
      cycle();
      n_checks++;
      if (led !== m_led || tick !== m_tick) begin
        n_errors++;
        $display("FAIL breathe_cycle c=%0d led=%b tick=%b want led=%b tick=%b",
                 c, led, tick, m_led, m_tick);
      end
      if (m_tick) begin win = 0; ones = 0; end
      if (win < 4) begin
        if (led == 4'hF) ones++;
        win++;
        if (win == 4 && nt < 7) begin
          n_checks++;
          if (ones != exp_on[nt]) begin
            n_errors++;
            $display("FAIL breathe_duty%0d on_cycles=%0d want %0d", nt, ones, exp_on[nt]);
          end
          nt++;
        end
      end
    end
`else
    tbl = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF};
    test_pattern("breathe_off", 2'b11, 30);
`endif
  endtask

  task automatic test_mode_change();
    int         nt = 0;
    logic [3:0] saved;
    logic       got = 1'b0;
    do_reset(2'b01);
    for (int c = 0; c < 20 && nt < 2; c++) begin
      cycle();
      if (m_tick) nt++;
    end
    cycle();
    cycle();
    mode  = 2'b10;
    saved = led;
    n_checks++;
    if (saved !== 4'b0010) begin
      n_errors++;
      $display("FAIL mode_change_pre led=%b want 0010", saved);
    end
    for (int c = 0; c < 10 && !got; c++) begin
      cycle();
      n_checks++;
      if (!m_tick) begin
        if (led !== saved || tick !== 1'b0) begin
          n_errors++;
          $display("FAIL mode_change_hold led=%b tick=%b want led=%b tick=0", led, tick, saved);
        end
      end else begin
        got = 1'b1;
        if (led !== 4'b0001 || tick !== 1'b1) begin
          n_errors++;
          $display("FAIL mode_change_load led=%b tick=%b want led=0001 tick=1", led, tick);
        end
      end
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL mode_change_timeout got no step want one within 10 cycles");
    end
  endtask

  task automatic test_enable_freeze();
    int         nrun;
    int         since = 0;
    int         wait_c = -1;
    logic [3:0] saved;
    do_reset(2'b01);
    nrun = $urandom_range(11, 19);
    for (int c = 0; c < nrun; c++) begin
      cycle();
      since = m_tick ? 0 : since + 1;
    end
    saved  = led;
    enable = 1'b0;
    for (int c = 0; c < 30; c++) begin
      cycle();
      n_checks++;
      if (led !== saved || tick !== 1'b0) begin
        n_errors++;
        $display("FAIL freeze_hold c=%0d led=%b tick=%b want led=%b tick=0", c, led, tick, saved);
      end
    end
    enable = 1'b1;
    for (int c = 1; c <= 10 && wait_c < 0; c++) begin
      cycle();
      if (tick) wait_c = c;
    end
    n_checks++;
    if (since + wait_c != DIV) begin
      n_errors++;
      $display("FAIL freeze_resume cycles_to_tick=%0d want %0d", wait_c, DIV - since);
    end
    n_checks++;
    if (led !== {saved[2:0], saved[3]}) begin
      n_errors++;
      $display("FAIL freeze_next led=%b want %b", led, {saved[2:0], saved[3]});
    end
  endtask

  task automatic test_reset_mid();
    int wait_c = -1;
    do_reset(2'b10);
    for (int c = 0; c < int'($urandom_range(8, 25)); c++) cycle();
    reset = 1'b1;
    cycle();
    n_checks++;
    if (led !== 4'h0 || tick !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid led=%b tick=%b want led=0000 tick=0", led, tick);
    end
    reset = 1'b0;
    for (int c = 1; c <= 10 && wait_c < 0; c++) begin
      cycle();
      if (tick) wait_c = c;
    end
    n_checks++;
    if (wait_c != DIV || led !== 4'b0001) begin
      n_errors++;
      $display("FAIL reset_mid_restart tick_at=%0d led=%b want tick_at=%0d led=0001",
               wait_c, led, DIV);
    end
  endtask

  task automatic test_random();
    do_reset(2'($urandom_range(0, 3)));
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 4) != 0);
      reset  = ($urandom_range(0, 63) == 0);
      cycle();
      n_checks++;
      if (led !== m_led || tick !== m_tick) begin
        n_errors++;
        $display("FAIL random_cycle c=%0d led=%b tick=%b want led=%b tick=%b",
                 c, led, tick, m_led, m_tick);
      end
    end
    reset  = 1'b0;
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    tbl = '{4'hF, 4'h0, 4'hF};
    test_pattern("blink", 2'b00, 16);
    tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    test_pattern("chase", 2'b01, 26);
    tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    test_pattern("bounce", 2'b10, 41);
    test_breathe();
    test_mode_change();
    test_enable_freeze();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
